seq_restoring_divider: RTL and testbench

Multi-cycle unsigned restoring divider. It is the inverse-operation companion to the combinational add/subtract datapath and reuses the same trial-subtract principle, one quotient bit per clock. It takes a start/done handshake from a controller and returns quotient, remainder and a divide-by-zero flag. Outputs stay stable until the next accepted start.

---
 rtl/seq_restoring_divider.sv | 106 ++++++++++
 tb/tb_seq_restoring_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle unsigned restoring divider, one quotient bit per clock

module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;
  logic             r_dbz;

  logic             w_carry;
  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // One iteration: shift {R,Q} left, trial-subtract D, keep the difference only if it did not borrow.
  // The bit shifted out of R is kept as a carry so large divisors never lose the top partial-remainder bit.
  always_comb begin
    w_carry    = r_rem[WIDTH-1];
    w_rem_sh   = {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
    w_trial    = {1'b0, w_rem_sh} - {1'b0, r_d};
    w_fits     = w_carry | ~w_trial[WIDTH];
    w_rem_next = w_fits ? w_trial[WIDTH-1:0] : w_rem_sh;
    w_q_next   = {r_q[WIDTH-2:0], w_fits};
  end

  // Control FSM, working Q/R registers and the held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem_out <= '0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              r_rem   <= '0;
              r_q     <= dividend;
              r_d     <= divisor;
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_state <= S_RUN;
            end else begin
              r_quot    <= '1;
              r_rem_out <= dividend;
              r_dbz     <= 1'b1;
              r_done    <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST_ITER) begin
            r_quot    <= w_q_next;
            r_rem_out <= w_rem_next;
            r_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider at WIDTH 4 and 8

module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s4_start, s8_start;
  logic [3:0] s4_a, s4_b, q4, r4;
  logic [7:0] s8_a, s8_b, q8, r8;
  logic       b4, d4, z4, b8, d8, z8;

  int n_assert = 0;
  int n_fail   = 0;
  bit sel8     = 1'b0;
  int wdth     = 4;

  logic [7:0] cur_q, cur_r;
  logic       cur_busy, cur_done, cur_dbz;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(4)) u_div4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .dividend(s4_a), .divisor(s4_b),
    .busy(b4), .done(d4), .quotient(q4), .remainder(r4), .div_by_zero(z4)
  );

  seq_restoring_divider #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .dividend(s8_a), .divisor(s8_b),
    .busy(b8), .done(d8), .quotient(q8), .remainder(r8), .div_by_zero(z8)
  );

  always_comb begin
    cur_q    = sel8 ? q8 : {4'b0, q4};
    cur_r    = sel8 ? r8 : {4'b0, r4};
    cur_busy = sel8 ? b8 : b4;
    cur_done = sel8 ? d8 : d4;
    cur_dbz  = sel8 ? z8 : z4;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b);
    if (sel8) begin
      s8_start = st; s8_a = a; s8_b = b;
    end else begin
      s4_start = st; s4_a = a[3:0]; s4_b = b[3:0];
    end
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    drive(1'b1, a, b);
  endtask

  // Waits for the result of an already-launched a/b and checks it against plain arithmetic.
  task automatic wait_result(input logic [7:0] a, input logic [7:0] b, input bit hold,
                             input logic [7:0] ha, input logic [7:0] hb, input bit tail);
    int n = 0;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    int mask = (1 << wdth) - 1;
    int eq, er, lat;
    eq  = (b == 0) ? mask : int'(a) / int'(b);
    er  = (b == 0) ? int'(a) : int'(a) % int'(b);
    lat = (b == 0) ? 1 : wdth + 1;
    while (n < 40 && !seen) begin
      @(negedge clk);
      if (hold) drive(1'b1, ha, hb);
      else drive(1'b0, 8'd0, 8'd0);
      n++;
      if (cur_done === 1'b1) seen = 1'b1;
      else if (cur_busy !== (b != 0)) busy_ok = 1'b0;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", n, lat);
    chk("busy_profile", 32'(busy_ok), 32'd1);
    chk("busy_at_done", 32'(cur_busy), 32'd0);
    chk("quotient", 32'(cur_q), eq);
    chk("remainder", 32'(cur_r), er);
    chk("div_by_zero", 32'(cur_dbz), 32'(b == 0));
    if (b != 0) begin
      chk("invariant", int'(cur_q) * int'(b) + int'(cur_r), int'(a));
      chk("rem_lt_div", 32'(cur_r < b), 32'd1);
    end
    if (tail) begin
      @(negedge clk);
      chk("done_single", 32'(cur_done), 32'd0);
      chk("quotient_hold", 32'(cur_q), eq);
    end
  endtask

  initial begin
    int dcount;
    logic [7:0] ra, rb;
    rst_n = 1'b0;
    s4_start = 1'b0; s4_a = '0; s4_b = '0;
    s8_start = 1'b0; s8_a = '0; s8_b = '0;
    #12;
    chk("rst_busy4", 32'(b4), 0); chk("rst_done4", 32'(d4), 0);
    chk("rst_q4", 32'(q4), 0);    chk("rst_r4", 32'(r4), 0);
    chk("rst_dbz4", 32'(z4), 0);  chk("rst_q8", 32'(q8), 0);
    @(negedge clk);
    rst_n = 1'b1;

    sel8 = 1'b0; wdth = 4;
    launch(8'd13, 8'd3); wait_result(8'd13, 8'd3, 0, 0, 0, 1);
    launch(8'd15, 8'd1); wait_result(8'd15, 8'd1, 0, 0, 0, 1);
    launch(8'd5,  8'd9); wait_result(8'd5,  8'd9, 0, 0, 0, 1);
    launch(8'd7,  8'd0); wait_result(8'd7,  8'd0, 0, 0, 0, 1);
    launch(8'd8,  8'd2); wait_result(8'd8,  8'd2, 0, 0, 0, 1);

    // Start held with new operands during RUN is ignored, then accepted in the done cycle.
    launch(8'd12, 8'd5);
    wait_result(8'd12, 8'd5, 1, 8'd9, 8'd3, 0);
    wait_result(8'd9, 8'd3, 0, 0, 0, 1);

    // Asynchronous reset in the middle of RUN aborts with no done.
    launch(8'd12, 8'd5);
    @(negedge clk); drive(1'b0, 8'd0, 8'd0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(b4), 0); chk("midrst_done", 32'(d4), 0);
    chk("midrst_q", 32'(q4), 0);    chk("midrst_r", 32'(r4), 0);
    chk("midrst_dbz", 32'(z4), 0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (d4 === 1'b1 || b4 === 1'b1) dcount++;
    end
    chk("midrst_no_done", dcount, 0);
    launch(8'd10, 8'd4); wait_result(8'd10, 8'd4, 0, 0, 0, 1);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(8'(a), 8'(b));
        wait_result(8'(a), 8'(b), 0, 0, 0, 1);
      end
    end

    sel8 = 1'b1; wdth = 8;
    launch(8'd255, 8'd255); wait_result(8'd255, 8'd255, 0, 0, 0, 1);
    launch(8'd254, 8'd255); wait_result(8'd254, 8'd255, 0, 0, 0, 1);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = (i % 50 == 0) ? 8'd0 : 8'($urandom);
      launch(ra, rb);
      wait_result(ra, rb, 0, 0, 0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
